apb_slave_mem: RTL



---
 rtl/apb_slv_pkg.sv | 15 +
 rtl/apb_slv_wait_ctr.sv | 31 +++
 rtl/apb_slave_mem.sv | 111 +++++++++++
 3 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and defaults for the APB register-file completer.
package apb_slv_pkg;

  localparam int unsigned WAIT_W    = 4;
  localparam int unsigned AW_DEF    = 8;
  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_slv_state_e;

endpackage

// File: rtl/apb_slv_wait_ctr.sv
// Wait-state down-counter: loads the per-transfer wait count, decrements while
// waiting and flags the final wait cycle. Never wraps below zero.
module apb_slv_wait_ctr
  import apb_slv_pkg::*;
(
  input  logic              pclk,
  input  logic              presetn,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  input  logic              clr,
  output logic              last
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == WAIT_W'(1));

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a DEPTH x DW register file with programmable wait states.
// Define APB_SLV_ERR_EN to flag out-of-range accesses with pslverr instead of aliasing.
module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_slv_state_e state;
  logic [AW-1:0]  addr_q;
  logic           wr_q;
  logic [DW-1:0]  wdata_q;
  logic           err_q;
  logic [DW-1:0]  mem [DEPTH];

  logic           setup, accept, finish_wait, abort, cpl;
  logic [AW-1:0]  cpl_addr;
  logic           cpl_wr, cpl_oor, ctr_last, mem_we;
  logic [DW-1:0]  rd_word;

  // A zero-wait transfer completes straight out of SETUP, so the completion
  // path looks at the live bus address; otherwise it uses the latched one.
  always_comb begin
    setup       = psel && !penable;
    accept      = setup && ((state == IDLE) || (state == DONE));
    finish_wait = (state == WAIT) && psel && ctr_last;
    abort       = (state == WAIT) && !psel;
    cpl         = (accept && (WAIT_CYCLES == 0)) || finish_wait;
    cpl_addr    = accept ? paddr : addr_q;
    cpl_wr      = accept ? pwrite : wr_q;
    rd_word     = mem[IW'(cpl_addr)];
    mem_we      = (state == DONE) && wr_q && !err_q;
  end

`ifdef APB_SLV_ERR_EN
  assign cpl_oor = (32'(cpl_addr) >= DEPTH);
`else
  assign cpl_oor = 1'b0;
`endif

  apb_slv_wait_ctr u_wait_ctr (
    .pclk     (pclk),
    .presetn  (presetn),
    .load     (accept),
    .load_val (WAIT_W'(WAIT_CYCLES)),
    .dec      ((state == WAIT) && psel),
    .clr      (abort),
    .last     (ctr_last)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      pready  <= cpl;
      pslverr <= cpl && cpl_oor;
      if (cpl && !cpl_wr) begin
        prdata <= cpl_oor ? '0 : rd_word;
      end
      if (accept) begin
        addr_q  <= paddr;
        wr_q    <= pwrite;
        wdata_q <= pwdata;
        err_q   <= cpl_oor;
      end
      case (state)
        IDLE:    if (accept) state <= (WAIT_CYCLES == 0) ? DONE : WAIT;
        WAIT: begin
          if (abort)            state <= IDLE;
          else if (finish_wait) state <= DONE;
        end
        DONE:    state <= accept ? ((WAIT_CYCLES == 0) ? DONE : WAIT) : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[IW'(addr_q)] <= wdata_q;
    end
  end

endmodule
